i2s_source_gen: RTL and testbench

Parametrised, synthesisable I2S slave transmitter and pattern source. It replaces the fixed behavioural I2S stimulus model in SoC-level benches and can also sit on-chip as a loopback source for the I2S receiver. It follows externally supplied BCLK and WS from the I2S master and drives serial data (DIN). Each left/right sample comes from a selectable pattern generator, with configurable sample width, slot width and framing mode.

---
 rtl/i2s_source_gen.sv | 156 +++++++++++++++
 tb/tb_i2s_source_gen.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_source_gen.sv
// I2S slave transmitter that follows an external BCLK/WS pair and serialises
// samples from a counter, LFSR, constant or square-wave pattern source.
`timescale 1ns/1ps
module i2s_source_gen #(
   parameter int          DATA_W    = 16,
   parameter int          SLOT_W    = 32,
   parameter int          MODE      = 0,
   parameter int          SQ_HALF   = 4,
   parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              en,
   input  logic [1:0]        pattern_sel,
   input  logic [DATA_W-1:0] const_val,
   input  logic              BCLK,
   input  logic              WS,
   output logic              DIN,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int                PW        = $clog2(SLOT_W + 1);
   localparam int                SQW       = $clog2(SQ_HALF + 1);
   localparam logic [DATA_W-1:0] SQ_MIN    = DATA_W'(1) << (DATA_W - 1);
   localparam logic [DATA_W-1:0] SQ_MAX    = ~SQ_MIN;
   localparam logic [31:0]       LFSR_TAPS = 32'h8020_0003;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
   endfunction

   logic              bclk_s1_r, bclk_s2_r, bclk_d_r;
   logic              ws_s1_r, ws_s2_r, ws_prev_r;
   logic              pending_r, busy_r, din_r;
   logic [DATA_W-1:0] sr_r, cnt_r, sample_s;
   logic [PW-1:0]     bit_pos_r;
   logic [31:0]       lfsr_r;
   logic              sq_low_r;
   logic [SQW-1:0]    sq_cnt_r;
   logic [15:0]       frame_cnt_r;
   logic              fall_s, ws_chg_s, arm_s, load_s, pend_s;

   // Edge detection, arming and load decisions, plus the sample mux.
   always_comb begin
      fall_s   = bclk_d_r & ~bclk_s2_r;
      ws_chg_s = ws_s2_r ^ ws_prev_r;
      arm_s    = en & fall_s & ~busy_r & ws_chg_s & ~ws_s2_r;
      if (MODE == 1) begin
         load_s = en & fall_s & ws_chg_s & (busy_r | arm_s);
         pend_s = 1'b0;
      end else begin
         load_s = en & fall_s & busy_r & pending_r;
         pend_s = en & fall_s & ws_chg_s & (busy_r | arm_s);
      end
      case (pattern_sel)
         2'd0:    sample_s = ws_s2_r ? ~cnt_r : cnt_r;
         2'd1:    sample_s = lfsr_r[31 -: DATA_W];
         2'd2:    sample_s = const_val;
         2'd3:    sample_s = sq_low_r ? SQ_MIN : SQ_MAX;
         default: sample_s = cnt_r;
      endcase
   end

   // Two-flop synchronisers for BCLK/WS, BCLK edge register and WS history.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         bclk_s1_r <= 1'b0;
         bclk_s2_r <= 1'b0;
         bclk_d_r  <= 1'b0;
         ws_s1_r   <= 1'b0;
         ws_s2_r   <= 1'b0;
         ws_prev_r <= 1'b0;
      end else begin
         bclk_s1_r <= BCLK;
         bclk_s2_r <= bclk_s1_r;
         bclk_d_r  <= bclk_s2_r;
         ws_s1_r   <= WS;
         ws_s2_r   <= ws_s1_r;
         if (fall_s) begin
            ws_prev_r <= ws_s2_r;
         end
      end
   end

   // Arming state and the serial shifter; dropping en overrides any load.
   always_ff @(posedge HCLK) begin
      if (HRESET || !en) begin
         busy_r    <= 1'b0;
         pending_r <= 1'b0;
         din_r     <= 1'b0;
         sr_r      <= '0;
         bit_pos_r <= PW'(SLOT_W);
      end else if (fall_s) begin
         if (arm_s) begin
            busy_r <= 1'b1;
         end
         pending_r <= pend_s;
         if (load_s) begin
            din_r     <= sample_s[DATA_W-1];
            sr_r      <= sample_s << 1'b1;
            bit_pos_r <= PW'(1);
         end else if (busy_r) begin
            // Past the sample width the slot is padded with zeros.
            if (bit_pos_r < PW'(DATA_W)) begin
               din_r <= sr_r[DATA_W-1];
               sr_r  <= sr_r << 1'b1;
            end else begin
               din_r <= 1'b0;
            end
            if (bit_pos_r < PW'(SLOT_W)) begin
               bit_pos_r <= bit_pos_r + PW'(1);
            end
         end
      end
   end

   // Pattern generators and frame counter advance only on word loads.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         cnt_r       <= '0;
         lfsr_r      <= LFSR_SEED;
         sq_low_r    <= 1'b0;
         sq_cnt_r    <= '0;
         frame_cnt_r <= 16'd0;
      end else if (load_s) begin
         case (pattern_sel)
            2'd0: begin
               if (ws_s2_r) begin
                  cnt_r <= cnt_r + DATA_W'(1);
               end
            end
            2'd1: lfsr_r <= lfsr_step(lfsr_r);
            2'd3: begin
               if (ws_s2_r) begin
                  if (sq_cnt_r == SQW'(SQ_HALF - 1)) begin
                     sq_cnt_r <= '0;
                     sq_low_r <= ~sq_low_r;
                  end else begin
                     sq_cnt_r <= sq_cnt_r + SQW'(1);
                  end
               end
            end
            default: ;
         endcase
         if (ws_s2_r) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end
      end
   end

   assign DIN       = din_r;
   assign busy      = busy_r;
   assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_i2s_source_gen.sv
// Bench for i2s_source_gen: drives an I2S master on BCLK/WS and compares the
// serial words of a Philips and a left-justified instance against a word model.
`timescale 1ns/1ps
module tb_i2s_source_gen;

   localparam int DW = 16;
   localparam int SLOT_W = 32;
   localparam int SQ_HALF = 2;

   logic HCLK, HRESET, en, BCLK, WS;
   logic [1:0] pattern_sel;
   logic [DW-1:0] const_val;
   logic din0, busy0, din1, busy1;
   logic [15:0] fc0, fc1;

   int checks = 0;
   int passes = 0;

   // model state: words are derived from frame indices and the polynomial
   int m_cnt, m_sqk, m_frames;
   logic [31:0] m_lfsr;
   bit m_armed, m_prev;

   // observations taken inside a slot
   logic pre1, post1, a_din0, a_din1, a_busy0, a_busy1;
   logic [15:0] a_fc0, a_fc1;

   i2s_source_gen #(.DATA_W(DW), .SLOT_W(SLOT_W), .MODE(0), .SQ_HALF(SQ_HALF)) dut0 (
      .HCLK(HCLK), .HRESET(HRESET), .en(en), .pattern_sel(pattern_sel),
      .const_val(const_val), .BCLK(BCLK), .WS(WS), .DIN(din0), .busy(busy0),
      .frame_cnt(fc0));

   i2s_source_gen #(.DATA_W(DW), .SLOT_W(SLOT_W), .MODE(1), .SQ_HALF(SQ_HALF)) dut1 (
      .HCLK(HCLK), .HRESET(HRESET), .en(en), .pattern_sel(pattern_sel),
      .const_val(const_val), .BCLK(BCLK), .WS(WS), .DIN(din1), .busy(busy1),
      .frame_cnt(fc1));

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // one step of x^32+x^22+x^2+x+1: the dropped x^0 coefficient folds into x^31,x^21,x^1,x^0
   function automatic logic [31:0] galois(input logic [31:0] s);
      logic [31:0] n;
      n = s >> 1;
      if (s[0]) begin
         n[31] = 1'b1;
         n[21] = ~n[21];
         n[1]  = ~n[1];
         n[0]  = ~n[0];
      end
      return n;
   endfunction

   task automatic model_reset();
      m_cnt = 0; m_sqk = 0; m_frames = 0; m_lfsr = 32'hACE1_0001; m_armed = 1'b0;
   endtask

   // expected slot bit streams (MSB = first bit) for the MODE 0 and MODE 1 instances
   task automatic model_slot(input bit ch, output logic [31:0] e0, output logic [31:0] e1);
      logic [15:0] w;
      if (en && !m_armed && ch == 1'b0 && m_prev == 1'b1) m_armed = 1'b1;
      m_prev = ch;
      if (!m_armed) begin
         e0 = 32'h0; e1 = 32'h0;
      end else begin
         case (pattern_sel)
            2'd0: begin
               w = 16'(m_cnt);
               if (ch) begin w = ~w; m_cnt = m_cnt + 1; end
            end
            2'd1: begin w = m_lfsr[31:16]; m_lfsr = galois(m_lfsr); end
            2'd2: w = const_val;
            default: begin
               w = (((m_sqk / SQ_HALF) % 2) == 0) ? 16'h7FFF : 16'h8000;
               if (ch) m_sqk = m_sqk + 1;
            end
         endcase
         if (ch) m_frames = m_frames + 1;
         e0 = {16'h0, w} << 15;
         e1 = {16'h0, w} << 16;
      end
   endtask

   // one channel slot of SLOT_W bit clocks, half period 5 HCLK; act 1=drop en, 2=reset, 3=raise en
   task automatic run_slot(input bit ch, input int act_at, input int act,
                           output logic [31:0] c0, output logic [31:0] c1);
      c0 = 32'h0; c1 = 32'h0;
      for (int b = 0; b < SLOT_W; b++) begin
         BCLK = 1'b0; WS = ch;
         #24;
         if (b == 0) pre1 = din1;
         #2;
         if (b == 0) post1 = din1;
         #4;
         c0[SLOT_W-1-b] = din0;
         c1[SLOT_W-1-b] = din1;
         if (b == act_at) begin
            if (act == 1) en = 1'b0;
            else if (act == 2) HRESET = 1'b1;
            else en = 1'b1;
            #10;
            a_din0 = din0; a_din1 = din1; a_busy0 = busy0; a_busy1 = busy1;
            a_fc0 = fc0; a_fc1 = fc1;
            HRESET = 1'b0;
            #10;
         end else begin
            #20;
         end
         BCLK = 1'b1;
         #50;
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1; en = 1'b0; pattern_sel = 2'd0; const_val = 16'h0; BCLK = 1'b1; WS = 1'b1;
      #100;
      checks++; if ({din0, busy0, fc0} !== 18'h0) $display("FAIL reset_dut0: got din/busy/fc %h want 0", {din0, busy0, fc0}); else passes++;
      checks++; if ({din1, busy1, fc1} !== 18'h0) $display("FAIL reset_dut1: got din/busy/fc %h want 0", {din1, busy1, fc1}); else passes++;
      HRESET = 1'b0;
      #100;
      model_reset(); m_prev = 1'b1;
   endtask

   task automatic test_counter();
      logic [31:0] c0, c1, e0, e1;
      pattern_sel = 2'd0; en = 1'b1;
      for (int s = -1; s < 8; s++) begin
         bit ch = (s < 0) ? 1'b1 : 1'(s % 2);
         model_slot(ch, e0, e1); run_slot(ch, -1, 0, c0, c1);
         checks++; if (c0 !== e0) $display("FAIL counter_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL counter_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
         if (s == 1) begin
            checks++; if (c0 !== 32'h7FFF_8000) $display("FAIL counter_first_right: got %h want 7fff8000", c0); else passes++;
         end
         if (s == 3) begin
            checks++; if (fc0 !== 16'd2 || fc1 !== 16'd2) $display("FAIL counter_frames: got %0d/%0d want 2", fc0, fc1); else passes++;
         end
      end
      checks++; if (busy0 !== 1'b1 || busy1 !== 1'b1) $display("FAIL counter_busy: got %b%b want 11", busy0, busy1); else passes++;
   endtask

   task automatic test_mode1_const();
      logic [31:0] c0, c1, e0, e1;
      pattern_sel = 2'd2; const_val = 16'h8001;
      for (int s = 0; s < 6; s++) begin
         bit ch = 1'(s % 2);
         if (s == 4) const_val = 16'($urandom);
         model_slot(ch, e0, e1); run_slot(ch, -1, 0, c0, c1);
         checks++; if (c0 !== e0) $display("FAIL const_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL const_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
         if (s < 4) begin
            checks++; if (pre1 !== 1'b0 || post1 !== 1'b1) $display("FAIL msb_timing slot %0d: got %b%b want 01", s, pre1, post1); else passes++;
         end
      end
   endtask

   task automatic test_square();
      logic [31:0] c0, c1, e0, e1;
      pattern_sel = 2'd3;
      for (int s = 0; s < 10; s++) begin
         bit ch = 1'(s % 2);
         model_slot(ch, e0, e1); run_slot(ch, -1, 0, c0, c1);
         checks++; if (c0 !== e0) $display("FAIL square_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL square_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
      end
   endtask

   task automatic test_lfsr();
      logic [31:0] c0, c1, e0, e1;
      pattern_sel = 2'd1;
      for (int s = 0; s < 4; s++) begin
         bit ch = 1'(s % 2);
         model_slot(ch, e0, e1); run_slot(ch, -1, 0, c0, c1);
         checks++; if (c0 !== e0) $display("FAIL lfsr_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL lfsr_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
         if (s == 0) begin
            checks++; if (c1 !== 32'hACE1_0000) $display("FAIL lfsr_first: got %h want ace10000", c1); else passes++;
         end
         if (s == 1) begin
            checks++; if (c1 !== 32'hD650_0000) $display("FAIL lfsr_second: got %h want d6500000", c1); else passes++;
         end
      end
   endtask

   task automatic test_enable();
      logic [31:0] c0, c1, e0, e1, keep;
      logic [15:0] frozen;
      pattern_sel = 2'd2; const_val = 16'hFFFF;
      keep = 32'hFFFF_FFFF << (SLOT_W - 1 - 5);
      for (int s = 0; s < 6; s++) begin
         bit ch = 1'(s % 2);
         model_slot(ch, e0, e1);
         if (s == 0) begin
            run_slot(ch, 5, 1, c0, c1);
            e0 = e0 & keep; e1 = e1 & keep; m_armed = 1'b0;
            frozen = 16'(m_frames);
            checks++; if ({a_din0, a_din1, a_busy0, a_busy1} !== 4'b0000) $display("FAIL en_drop: got din/busy %b want 0000", {a_din0, a_din1, a_busy0, a_busy1}); else passes++;
         end else if (s == 3) begin
            run_slot(ch, 10, 3, c0, c1);
            checks++; if (fc0 !== frozen || fc1 !== frozen) $display("FAIL en_frozen: got %0d/%0d want %0d", fc0, fc1, frozen); else passes++;
         end else begin
            run_slot(ch, -1, 0, c0, c1);
         end
         checks++; if (c0 !== e0) $display("FAIL enable_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL enable_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
      end
      checks++; if (fc0 !== 16'(m_frames)) $display("FAIL en_resume_frames: got %0d want %0d", fc0, m_frames); else passes++;
   endtask

   task automatic test_reset_mid_word();
      logic [31:0] c0, c1, e0, e1, keep;
      pattern_sel = 2'd0;
      keep = 32'hFFFF_FFFF << (SLOT_W - 1 - 5);
      for (int s = 0; s < 6; s++) begin
         bit ch = 1'(s % 2);
         model_slot(ch, e0, e1);
         if (s == 0) begin
            run_slot(ch, 5, 2, c0, c1);
            e0 = e0 & keep; e1 = e1 & keep; model_reset();
            checks++; if ({a_din0, a_din1, a_busy0, a_fc0, a_fc1} !== 35'h0) $display("FAIL rst_mid: got din %b%b busy %b fc %0d/%0d want 0", a_din0, a_din1, a_busy0, a_fc0, a_fc1); else passes++;
         end else begin
            run_slot(ch, -1, 0, c0, c1);
         end
         checks++; if (c0 !== e0) $display("FAIL rstmid_m0 slot %0d: got %h want %h", s, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL rstmid_m1 slot %0d: got %h want %h", s, c1, e1); else passes++;
         if (s == 3) begin
            checks++; if (c0 !== 32'h7FFF_8000 || fc0 !== 16'd1) $display("FAIL rst_first_frame: got %h fc %0d want 7fff8000 fc 1", c0, fc0); else passes++;
         end
      end
   endtask

   task automatic test_random_mix();
      logic [31:0] c0, c1, e0, e1;
      for (int s = 0; s < 16; s++) begin
         bit ch = 1'(s % 2);
         if (!ch) begin
            pattern_sel = 2'($urandom_range(0, 3));
            const_val = 16'($urandom);
         end
         model_slot(ch, e0, e1); run_slot(ch, -1, 0, c0, c1);
         checks++; if (c0 !== e0) $display("FAIL mix_m0 slot %0d pat %0d: got %h want %h", s, pattern_sel, c0, e0); else passes++;
         checks++; if (c1 !== e1) $display("FAIL mix_m1 slot %0d pat %0d: got %h want %h", s, pattern_sel, c1, e1); else passes++;
         if (ch) begin
            checks++; if (fc0 !== 16'(m_frames) || fc1 !== 16'(m_frames)) $display("FAIL mix_frames: got %0d/%0d want %0d", fc0, fc1, m_frames); else passes++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_counter();
      test_mode1_const();
      test_square();
      test_lfsr();
      test_enable();
      test_reset_mid_word();
      test_random_mix();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
